// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, parity modes and the parity helper.
// Used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int MAX_DATA_BITS = 9;

    // Callers zero-extend narrower characters, which leaves the XOR unchanged.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                        input logic [1:0] mode);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start, DATA_BITS data bits LSB first, optional
// even/odd parity, one or two stop bits, paced by an external oversample tick.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_tick,
    input  logic                 i_valid,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic [1:0]           i_parity,
    input  logic                 i_stop2,
    output logic                 o_ready,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_tx_done
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    uart_state_t          state_reg, state_next;
    logic [TW-1:0]        tick_cnt_reg, tick_cnt_next;
    logic [BW-1:0]        bit_cnt_reg, bit_cnt_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [1:0]           par_mode_reg, par_mode_next;
    logic                 par_bit_reg, par_bit_next;
    logic                 stop2_reg, stop2_next;
    logic                 tx_reg, tx_next;
    logic                 done_reg, done_next;

    logic                     bit_end;
    logic [MAX_DATA_BITS-1:0] data_ext;

    assign bit_end = i_tick && (tick_cnt_reg == TICK_LAST);

    always_comb begin
        data_ext = '0;
        data_ext[DATA_BITS-1:0] = i_data;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg    <= ST_IDLE;
            tick_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            par_mode_reg <= PAR_NONE;
            par_bit_reg  <= 1'b0;
            stop2_reg    <= 1'b0;
            tx_reg       <= 1'b1;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tick_cnt_reg <= tick_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            par_mode_reg <= par_mode_next;
            par_bit_reg  <= par_bit_next;
            stop2_reg    <= stop2_next;
            tx_reg       <= tx_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        tick_cnt_next = tick_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        par_mode_next = par_mode_reg;
        par_bit_next  = par_bit_reg;
        stop2_next    = stop2_reg;
        done_next     = 1'b0;
        tx_next       = 1'b1;

        // Counter wraps explicitly so non-power-of-two OVERSAMPLE values work.
        if (i_tick) begin
            tick_cnt_next = bit_end ? '0 : tick_cnt_reg + 1'b1;
        end

        case (state_reg)
            ST_IDLE: begin
                // A tick in the handshake cycle must not count toward the start bit.
                tick_cnt_next = '0;
                if (i_valid) begin
                    shift_next    = i_data;
                    par_mode_next = i_parity;
                    par_bit_next  = parity_bit(data_ext, i_parity);
                    stop2_next    = i_stop2;
                    bit_cnt_next  = '0;
                    state_next    = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_next = shift_reg >> 1;
                    if (bit_cnt_reg == LAST_BIT) begin
                        bit_cnt_next = '0;
                        state_next   = parity_enabled(par_mode_reg) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (stop2_reg && (bit_cnt_reg == '0)) begin
                        bit_cnt_next = BW'(1);
                    end else begin
                        bit_cnt_next = '0;
                        state_next   = ST_IDLE;
                        done_next    = 1'b1;
                    end
                end
            end
            default: begin
                tick_cnt_next = '0;
                state_next    = ST_IDLE;
            end
        endcase

        // Line level follows the state being entered, so o_tx moves with the state register.
        case (state_next)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = shift_next[0];
            ST_PARITY: tx_next = par_bit_next;
            default:   tx_next = 1'b1;
        endcase
    end

    assign o_tx      = tx_reg;
    assign o_tx_done = done_reg;
    assign o_ready   = (state_reg == ST_IDLE);
    assign o_busy    = (state_reg != ST_IDLE);

endmodule
